// File: rtl/req_arb_queue.sv
// -----------------------------------------------------------------------------
// req_arb_queue
//   Read/write command arbiter plus request FIFO placed in front of the memory
//   controller. At most one command is granted per cycle. When both requesters
//   collide, grants alternate between them in round-robin order. Each granted
//   command is queued as {rd_bwt, addr} in a 2**QAW-entry FIFO. The head entry
//   is presented first-word-fall-through.
//
// Ports
//   clk, rst_n          clock, asynchronous active-low reset
//   wcmd_wen / waddr    write-command request and address (held until ack)
//   wcmd_ack            write command enqueued this cycle (combinational)
//   rcmd_wen / raddr    read-command request and address (held until ack)
//   rcmd_ack            read command enqueued this cycle (combinational)
//   rnext               pop the head entry at this clock edge
//   rqempty             FIFO empty
//   qraddr / rd_bwt     head address and type (1 = read); both 0 when empty
//   qfull / qafull      qcount == DEPTH / qcount >= AFULL_TH
//   qcount              occupancy, 0..DEPTH
//   err_pop             sticky flag: rnext was seen while the FIFO was empty
// -----------------------------------------------------------------------------
module req_arb_queue #(
    parameter int AW       = 32,
    parameter int QAW      = 3,
    parameter int AFULL_TH = 6
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          wcmd_wen,
    input  logic [AW-1:0] waddr,
    output logic          wcmd_ack,
    input  logic          rcmd_wen,
    input  logic [AW-1:0] raddr,
    output logic          rcmd_ack,
    input  logic          rnext,
    output logic          rqempty,
    output logic [AW-1:0] qraddr,
    output logic          rd_bwt,
    output logic          qfull,
    output logic          qafull,
    output logic [QAW:0]  qcount,
    output logic          err_pop
);

    localparam int DEPTH = 1 << QAW;
    localparam logic [QAW:0] DEPTH_C = (QAW+1)'(DEPTH);
    localparam logic [QAW:0] AFULL_C = (QAW+1)'(AFULL_TH);
    localparam logic [QAW:0] ONE_C   = (QAW+1)'(1);

    logic [QAW-1:0] wptr_reg;
    logic [QAW-1:0] rptr_reg;
    logic [QAW:0]   qcount_reg;
    logic           prio_w_reg;
    logic           err_pop_reg;

    // Each entry holds {rd_bwt, addr}. The storage has no reset, and empty
    // slots are masked at the output instead.
    logic [AW:0] mem [DEPTH];

    logic        can_push;
    logic        grant_r;
    logic        grant_w;
    logic        push;
    logic        pop;
    logic [AW:0] wr_entry;
    logic [AW:0] head_entry;

    // A full queue refuses pushes even when the head is popped in the same
    // cycle. This keeps the grant path independent of rnext.
    assign can_push = rst_n & ~qfull;
    assign grant_r  = can_push & rcmd_wen & (~wcmd_wen | ~prio_w_reg);
    assign grant_w  = can_push & wcmd_wen & (~rcmd_wen |  prio_w_reg);
    assign rcmd_ack = grant_r;
    assign wcmd_ack = grant_w;

    assign push     = grant_r | grant_w;
    assign pop      = rnext & ~rqempty;
    assign wr_entry = grant_r ? {1'b1, raddr} : {1'b0, waddr};

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wptr_reg] <= wr_entry;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_reg    <= '0;
            rptr_reg    <= '0;
            qcount_reg  <= '0;
            prio_w_reg  <= 1'b0;
            err_pop_reg <= 1'b0;
        end else begin
            if (push) begin
                wptr_reg <= wptr_reg + 1'b1;
                // After a read is served the write side gets priority,
                // and after a write is served the read side does.
                prio_w_reg <= grant_r;
            end
            if (pop) begin
                rptr_reg <= rptr_reg + 1'b1;
            end
            if (rnext && rqempty) begin
                err_pop_reg <= 1'b1;
            end
            case ({push, pop})
                2'b10:   qcount_reg <= qcount_reg + ONE_C;
                2'b01:   qcount_reg <= qcount_reg - ONE_C;
                default: qcount_reg <= qcount_reg;
            endcase
        end
    end

    // The head is read combinationally, so a freshly pushed entry is visible
    // in the cycle after the write edge.
    assign head_entry = mem[rptr_reg];

    assign qcount  = qcount_reg;
    assign rqempty = (qcount_reg == '0);
    assign qfull   = (qcount_reg == DEPTH_C);
    assign qafull  = (qcount_reg >= AFULL_C);
    assign err_pop = err_pop_reg;
    assign qraddr  = rqempty ? '0 : head_entry[AW-1:0];
    assign rd_bwt  = rqempty ? 1'b0 : head_entry[AW];

endmodule

// File: tb/tb_req_arb_queue.sv
module tb_req_arb_queue;

    localparam int AW = 32;
    localparam int QAW = 3;
    localparam int DEPTH = 8;
    localparam int AFULL_TH = 6;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          wcmd_wen, rcmd_wen, rnext;
    logic [AW-1:0] waddr, raddr;
    logic          wcmd_ack, rcmd_ack;
    logic          rqempty, rd_bwt, qfull, qafull, err_pop;
    logic [AW-1:0] qraddr;
    logic [QAW:0]  qcount;

    req_arb_queue #(.AW(AW), .QAW(QAW), .AFULL_TH(AFULL_TH)) dut (
        .clk(clk), .rst_n(rst_n),
        .wcmd_wen(wcmd_wen), .waddr(waddr), .wcmd_ack(wcmd_ack),
        .rcmd_wen(rcmd_wen), .raddr(raddr), .rcmd_ack(rcmd_ack),
        .rnext(rnext), .rqempty(rqempty), .qraddr(qraddr), .rd_bwt(rd_bwt),
        .qfull(qfull), .qafull(qafull), .qcount(qcount), .err_pop(err_pop)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Scoreboard of expected head entries {rd_bwt, addr}, plus model state.
    logic [AW:0] sb_q[$];
    logic        m_prio;
    logic        m_err;
    logic        obs_r, obs_w;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    task automatic model_reset();
        sb_q.delete();
        m_prio = 1'b0;
        m_err  = 1'b0;
    endtask

    task automatic check_state(input string tag);
        check({tag, "_qcount"}, 64'(qcount), 64'(sb_q.size()));
        check({tag, "_empty"},  64'(rqempty), 64'(sb_q.size() == 0));
        check({tag, "_full"},   64'(qfull), 64'(sb_q.size() == DEPTH));
        check({tag, "_afull"},  64'(qafull), 64'(sb_q.size() >= AFULL_TH));
        check({tag, "_errpop"}, 64'(err_pop), 64'(m_err));
    endtask

    // One clock cycle. Inputs are already driven; the task is entered just
    // after a falling edge and returns on the next falling edge.
    task automatic step(input string tag);
        logic        full, gr, gw;
        logic [AW:0] exp;
        #1;
        full = (sb_q.size() == DEPTH);
        gr = rcmd_wen && !full && (!wcmd_wen || !m_prio);
        gw = wcmd_wen && !full && (!rcmd_wen ||  m_prio);
        obs_r = rcmd_ack;
        obs_w = wcmd_ack;
        check({tag, "_rack"}, 64'(rcmd_ack), 64'(gr));
        check({tag, "_wack"}, 64'(wcmd_ack), 64'(gw));
        if (rnext) begin
            if (sb_q.size() > 0) begin
                exp = sb_q.pop_front();
                check({tag, "_head_addr"}, 64'(qraddr), 64'(exp[AW-1:0]));
                check({tag, "_head_type"}, 64'(rd_bwt), 64'(exp[AW]));
                $display("pop  %s type=%0d addr=%08h", tag, rd_bwt, qraddr);
            end else begin
                m_err = 1'b1;
                $display("pop  %s on empty queue", tag);
            end
        end
        if (gr) begin
            sb_q.push_back({1'b1, raddr});
            m_prio = 1'b1;
            $display("push %s read  addr=%08h", tag, raddr);
        end else if (gw) begin
            sb_q.push_back({1'b0, waddr});
            m_prio = 1'b0;
            $display("push %s write addr=%08h", tag, waddr);
        end
        @(posedge clk);
        #1;
        check_state(tag);
        @(negedge clk);
    endtask

    task automatic drain(input string tag);
        rcmd_wen = 1'b0;
        wcmd_wen = 1'b0;
        rnext    = 1'b1;
        while (sb_q.size() > 0) step(tag);
        rnext = 1'b0;
    endtask

    initial begin
        model_reset();
        // Reset is held while both requesters are active.
        rst_n = 1'b0; wcmd_wen = 1'b1; rcmd_wen = 1'b1; rnext = 1'b0;
        waddr = 32'hB000_0000; raddr = 32'hA000_0000;
        #2;
        check("rst_rack", 64'(rcmd_ack), 64'(0));
        check("rst_wack", 64'(wcmd_ack), 64'(0));
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        check("rst_rack2", 64'(rcmd_ack), 64'(0));
        check("rst_wack2", 64'(wcmd_ack), 64'(0));
        check_state("rst");
        check("rst_qraddr", 64'(qraddr), 64'(0));
        check("rst_rdbwt", 64'(rd_bwt), 64'(0));
        wcmd_wen = 1'b0; rcmd_wen = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);

        // Collision: grants alternate R, W, R, W.
        wcmd_wen = 1'b1; rcmd_wen = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step("coll");
            check("coll_order_r", 64'(obs_r), 64'(i % 2 == 0));
            if (obs_r) raddr = raddr + 32'h4;
            if (obs_w) waddr = waddr + 32'h4;
        end
        wcmd_wen = 1'b0; rcmd_wen = 1'b0;
        check("coll_qcount", 64'(qcount), 64'(4));
        drain("coll_drain");

        // Fill to full with writes 0x100..0x107.
        wcmd_wen = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            waddr = 32'h100 + 32'(i);
            step("fill");
            if (i == 4) check("fill_afull_lo", 64'(qafull), 64'(0));
            if (i == 5) check("fill_afull_at6", 64'(qafull), 64'(1));
        end
        check("fill_full", 64'(qfull), 64'(1));
        waddr = 32'h108;
        step("full_blocked");
        check("full_noack", 64'(obs_w), 64'(0));
        rnext = 1'b1;
        step("full_pop");
        check("full_pop_noack", 64'(obs_w), 64'(0));
        rnext = 1'b0;
        step("full_retry");
        check("full_retry_ack", 64'(obs_w), 64'(1));
        wcmd_wen = 1'b0;
        drain("fill_drain");

        // Pointer wrap: 20 entries with a pop in the same cycle as most pushes.
        for (int i = 0; i < 20; i++) begin
            rcmd_wen = (i % 3 == 0);
            wcmd_wen = (i % 3 != 0);
            raddr = 32'h200 + 32'(i);
            waddr = 32'h200 + 32'(i);
            rnext = (i >= 2);
            step("wrap");
            if (i >= 2) check("wrap_qcount_const", 64'(qcount), 64'(2));
        end
        drain("wrap_drain");

        // Underflow is sticky, and the queue still works afterwards.
        rnext = 1'b1;
        step("under");
        rnext = 1'b0;
        step("under_idle");
        check("under_sticky", 64'(err_pop), 64'(1));
        wcmd_wen = 1'b1; waddr = 32'h300;
        step("under_push");
        wcmd_wen = 1'b0;
        check("under_head", 64'(qraddr), 64'(32'h300));
        drain("under_drain");

        // Reset asserted mid-operation, with 5 entries queued.
        wcmd_wen = 1'b1;
        for (int i = 0; i < 5; i++) begin
            waddr = 32'h400 + 32'(i);
            step("pre_rst");
        end
        wcmd_wen = 1'b0;
        check("pre_rst_qcount", 64'(qcount), 64'(5));
        #2 rst_n = 1'b0;
        model_reset();
        #1;
        check_state("async_rst");
        check("async_rst_qraddr", 64'(qraddr), 64'(0));
        wcmd_wen = 1'b1; rcmd_wen = 1'b1;
        #1;
        check("async_rst_rack", 64'(rcmd_ack), 64'(0));
        check("async_rst_wack", 64'(wcmd_ack), 64'(0));
        @(negedge clk);
        rst_n = 1'b1;
        raddr = 32'h500; waddr = 32'h600;
        step("post_rst");
        check("post_rst_read_first", 64'(obs_r), 64'(1));
        rcmd_wen = 1'b0; wcmd_wen = 1'b0;
        drain("post_rst_drain");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
